alpha_trim_mean: RTL and testbench

Consumes the rank-ordered index list from the parallel sorter and produces the modified-alpha-trimmed mean of a DN-sample window. It discards the TRIM smallest and TRIM largest samples, sums the middle N = DN−2·TRIM samples, and divides by N with rounding. It sits directly after the sorter in the Modified Alpha Mean filter pipeline and drives the filtered pixel output.

---
 rtl/alpha_trim_mean_if.sv | 24 ++
 rtl/alpha_trim_mean.sv | 125 ++++++++++++
 tb/tb_alpha_trim_mean.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/alpha_trim_mean_if.sv
// Handshake and data bus between the parallel sorter stage and the alpha-trimmed mean stage.
interface alpha_trim_mean_if #(
  parameter int DN          = 25,
  parameter int DW          = 8,
  parameter int DW_sequence = $clog2(DN)
);
  logic                        start;
  logic [DW*DN-1:0]            data_unsort;
  logic                        sort_finish;
  logic [DW_sequence*DN-1:0]   sequence_sorted;
  logic                        busy;
  logic [DW-1:0]               mean_out;
  logic                        mean_valid;

  modport master (
    output start, data_unsort, sort_finish, sequence_sorted,
    input  busy, mean_out, mean_valid
  );

  modport slave (
    input  start, data_unsort, sort_finish, sequence_sorted,
    output busy, mean_out, mean_valid
  );
endinterface

// File: rtl/alpha_trim_mean.sv
// Modified alpha-trimmed mean: sums the middle DN-2*TRIM ranked samples of a window
// and divides by that count with round-half-up, using a serial restoring divider.
module alpha_trim_mean #(
  parameter int DN          = 25,
  parameter int DW          = 8,
  parameter int DW_sequence = $clog2(DN),
  parameter int TRIM        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alpha_trim_mean_if.slave bus
);
  localparam int N    = DN - 2*TRIM;
  localparam int SUMW = DW + $clog2(N+1);
  localparam int RW   = $clog2(DN);
  localparam int CW   = $clog2(SUMW);

  localparam logic [RW-1:0]          R_FIRST   = RW'(TRIM);
  localparam logic [RW-1:0]          R_LAST    = RW'(DN-1-TRIM);
  localparam logic [CW-1:0]          D_LAST    = CW'(SUMW-1);
  localparam logic [SUMW-1:0]        N_W       = SUMW'(N);
  localparam logic [SUMW-1:0]        HALF      = SUMW'(N/2);
  localparam logic [DW_sequence:0]   IDX_LIMIT = (DW_sequence+1)'(DN);

  generate
    if (2*TRIM >= DN) begin : g_bad_trim
      $error("alpha_trim_mean: 2*TRIM must be smaller than DN");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LATCH, S_ACC, S_DIV, S_DONE} state_t;
  state_t state, state_nxt;

  logic [DW-1:0]          win [DN];
  logic [DW_sequence-1:0] idx [DN];
  logic [RW-1:0]          rank;
  logic [CW-1:0]          dcnt;
  logic [SUMW-1:0]        sum;
  logic [SUMW-1:0]        rem;
  logic [DW-1:0]          mean_q;

  logic [DW_sequence-1:0] cur_idx;
  logic [DW-1:0]          sample;
  logic [SUMW-1:0]        trial;
  logic                   trial_ge;
  logic [SUMW-1:0]        quo_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start)       state_nxt = S_WAIT;
      S_WAIT:  if (bus.sort_finish) state_nxt = S_LATCH;
      S_LATCH:                      state_nxt = S_ACC;
      S_ACC:   if (rank == R_LAST)  state_nxt = S_DIV;
      S_DIV:   if (dcnt == D_LAST)  state_nxt = S_DONE;
      S_DONE:                       state_nxt = S_IDLE;
      default:                      state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = (state != S_IDLE);
    bus.mean_valid = (state == S_DONE);
    bus.mean_out   = mean_q;
  end

  // Out-of-range indices select nothing so a corrupt permutation cannot read past the window.
  always_comb begin
    cur_idx = idx[rank];
    sample  = '0;
    if ({1'b0, cur_idx} < IDX_LIMIT) sample = win[cur_idx];
  end

  // Dividend shifts out of sum's MSB while quotient bits shift into its LSB.
  always_comb begin
    trial    = {rem[SUMW-2:0], sum[SUMW-1]};
    trial_ge = (trial >= N_W);
    quo_nxt  = {sum[SUMW-2:0], trial_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DN; k++) begin
        win[k] <= '0;
        idx[k] <= '0;
      end
      rank   <= '0;
      dcnt   <= '0;
      sum    <= '0;
      rem    <= '0;
      mean_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            for (int unsigned k = 0; k < DN; k++) win[k] <= bus.data_unsort[k*DW +: DW];
          end
        end
        S_LATCH: begin
          for (int unsigned k = 0; k < DN; k++) idx[k] <= bus.sequence_sorted[k*DW_sequence +: DW_sequence];
          rank <= R_FIRST;
          sum  <= HALF;
          rem  <= '0;
          dcnt <= '0;
        end
        S_ACC: begin
          sum  <= sum + SUMW'(sample);
          rank <= rank + 1'b1;
        end
        S_DIV: begin
          rem  <= trial_ge ? (trial - N_W) : trial;
          sum  <= quo_nxt;
          dcnt <= dcnt + 1'b1;
          if (dcnt == D_LAST) mean_q <= quo_nxt[DW-1:0];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alpha_trim_mean.sv
// Directed self-checking bench for alpha_trim_mean with hand-computed trimmed means.
module tb_alpha_trim_mean;
  localparam int DN  = 25;
  localparam int DW  = 8;
  localparam int DWS = 5;
  // Edges from the sort_finish sampling edge to the DONE cycle (LATCH + 17 ACC + 13 DIV).
  localparam int LAT = 31;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  alpha_trim_mean_if #(.DN(DN), .DW(DW)) bus ();

  alpha_trim_mean #(.DN(DN), .DW(DW), .TRIM(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0]  win_v  [DN];
  logic [DWS-1:0] perm_v [DN];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic identity_perm();
    for (int k = 0; k < DN; k++) perm_v[k] = DWS'(k);
  endtask

  task automatic scramble_data();
    for (int k = 0; k < DN; k++) bus.data_unsort[k*DW +: DW] = 8'($urandom);
  endtask

  // Drives start, then sort_finish in cycle S+gap; returns at the negedge after the sampling edge.
  task automatic launch(input int gap, input string tag);
    @(negedge clk);
    for (int k = 0; k < DN; k++) bus.data_unsort[k*DW +: DW] = win_v[k];
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    scramble_data();
    check({tag, "_busy_s1"}, 32'(bus.busy), 1);
    repeat (gap - 1) @(negedge clk);
    for (int k = 0; k < DN; k++) bus.sequence_sorted[k*DWS +: DWS] = perm_v[k];
    bus.sort_finish = 1'b1;
    @(negedge clk);
    bus.sort_finish = 1'b0;
  endtask

  task automatic run(input int gap, input logic [7:0] exp, input bit abuse, input string tag);
    int cnt;
    bit busy_ok;
    launch(gap, tag);
    cnt = 0;
    busy_ok = 1'b1;
    while (!bus.mean_valid && cnt < 60) begin
      @(negedge clk);
      cnt++;
      if (abuse && cnt == 5) begin
        bus.start = 1'b1;
        for (int k = 0; k < DN; k++) bus.data_unsort[k*DW +: DW] = 8'd255;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    bus.start = 1'b0;
    check({tag, "_lat"}, 32'(cnt), LAT);
    check({tag, "_busy"}, 32'(busy_ok), 1);
    check({tag, "_mean"}, 32'(bus.mean_out), 32'(exp));
    @(negedge clk);
    check({tag, "_vld_drop"}, 32'(bus.mean_valid), 0);
    check({tag, "_busy_drop"}, 32'(bus.busy), 0);
    check({tag, "_hold"}, 32'(bus.mean_out), 32'(exp));
  endtask

  task automatic quiet(input int cycles, input string tag);
    int pulses;
    int busies;
    pulses = 0;
    busies = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.mean_valid) pulses++;
      if (bus.busy) busies++;
    end
    check({tag, "_no_vld"}, 32'(pulses), 0);
    check({tag, "_no_busy"}, 32'(busies), 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.sort_finish = 1'b0;
    bus.data_unsort = '0;
    bus.sequence_sorted = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_vld", 32'(bus.mean_valid), 0);
    check("rst_mean", 32'(bus.mean_out), 0);
    rst_n = 1'b1;

    // Stray sort_finish while idle must do nothing.
    @(negedge clk);
    bus.sort_finish = 1'b1;
    @(negedge clk);
    bus.sort_finish = 1'b0;
    quiet(40, "stray");

    for (int k = 0; k < DN; k++) win_v[k] = 8'd100;
    identity_perm();
    run(3, 8'd100, 1'b0, "const");

    for (int k = 0; k < DN; k++) win_v[k] = 8'(k);
    run(1, 8'd12, 1'b0, "ramp");

    for (int k = 0; k < DN; k++) win_v[k] = (k < 4) ? 8'd0 : (k < 20) ? 8'd10 : (k == 20) ? 8'd19 : 8'd200;
    run(5, 8'd11, 1'b0, "rnd179");
    win_v[20] = 8'd18;
    run(2, 8'd10, 1'b0, "rnd178");

    for (int k = 0; k < DN; k++) win_v[k] = 8'd50;
    win_v[1] = 8'd255; win_v[7] = 8'd255; win_v[13] = 8'd255; win_v[22] = 8'd255;
    win_v[3] = 8'd0;   win_v[9] = 8'd0;   win_v[16] = 8'd0;   win_v[24] = 8'd0;
    perm_v = '{5'd24, 5'd16, 5'd3, 5'd9,
               5'd23, 5'd21, 5'd20, 5'd19, 5'd18, 5'd17, 5'd15, 5'd14, 5'd12,
               5'd11, 5'd10, 5'd8, 5'd6, 5'd5, 5'd4, 5'd2, 5'd0,
               5'd13, 5'd1, 5'd22, 5'd7};
    run(4, 8'd50, 1'b0, "outlier");

    for (int k = 0; k < DN; k++) win_v[k] = 8'd255;
    identity_perm();
    run(2, 8'd255, 1'b0, "full");

    // Rank 10 points outside the window: 16*100 contributes, (1600+8)/17 = 94.
    for (int k = 0; k < DN; k++) win_v[k] = 8'd100;
    perm_v[10] = 5'd31;
    run(3, 8'd94, 1'b0, "illegal");

    for (int k = 0; k < DN; k++) win_v[k] = 8'(k);
    identity_perm();
    run(3, 8'd12, 1'b1, "abuse");
    quiet(40, "abuse_after");

    // Reset in the middle of the divide phase.
    for (int k = 0; k < DN; k++) win_v[k] = (k < 4) ? 8'd0 : (k < 20) ? 8'd10 : (k == 20) ? 8'd19 : 8'd200;
    launch(2, "rstdiv");
    repeat (22) @(negedge clk);
    check("rstdiv_in_flight", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("rstdiv_busy", 32'(bus.busy), 0);
    check("rstdiv_mean", 32'(bus.mean_out), 0);
    check("rstdiv_vld", 32'(bus.mean_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet(40, "rstdiv_after");

    win_v[20] = 8'd18;
    run(2, 8'd10, 1'b0, "fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
